// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch stage: datapath width, the
//   default reset fetch address and the fetch controller state encoding.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // ST_REQ      : icache request outstanding, waiting for the response word
    // ST_DISPATCH : raw word presented to the Decoder, pushing when the IQ has room
    // ST_JSTALL   : jalr pushed, fetch idle until the ROB resolves the target
    typedef enum logic [1:0] {
        ST_REQ      = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_JSTALL   = 2'd2
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/inst_fetcher.sv
// -----------------------------------------------------------------------------
// inst_fetcher
//   Front-end fetch stage sitting directly upstream of the Decoder. Owns the
//   architectural fetch PC, issues one icache request at a time, hands the raw
//   word to the Decoder and pushes the Decoder's formalized instruction into the
//   instruction queue. All PC arithmetic happens in the Decoder; this block only
//   latches _dec_next_pc.
//
// Ports
//   clk_in, rst_in (sync, active-high), rdy_in (low freezes all state)
//   _br_rob                 ROB redirect; target arrives on _dec_next_pc
//   _ic_req/_ic_addr/_ic_abort, _ic_resp_valid/_ic_resp_data : icache side
//   _inst_out/_inst_ready_out/_inst_addr_out/_clear           : to Decoder
//   _dec_stall/_dec_next_pc/_dec_inst/_dec_rvc                : from Decoder
//   _iq_full, _iq_push/_iq_inst/_iq_pc/_iq_pred_pc/_iq_rvc    : instruction queue
// -----------------------------------------------------------------------------
module inst_fetcher
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,

    input  logic            _br_rob,

    output logic            _ic_req,
    output logic [XLEN-1:0] _ic_addr,
    output logic            _ic_abort,
    input  logic            _ic_resp_valid,
    input  logic [XLEN-1:0] _ic_resp_data,

    output logic [XLEN-1:0] _inst_out,
    output logic            _inst_ready_out,
    output logic [XLEN-1:0] _inst_addr_out,
    output logic            _clear,

    input  logic            _dec_stall,
    input  logic [XLEN-1:0] _dec_next_pc,
    input  logic [XLEN-1:0] _dec_inst,
    input  logic            _dec_rvc,

    input  logic            _iq_full,
    output logic            _iq_push,
    output logic [XLEN-1:0] _iq_inst,
    output logic [XLEN-1:0] _iq_pc,
    output logic [XLEN-1:0] _iq_pred_pc,
    output logic            _iq_rvc
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] inst_q,  inst_d;

    // Cycle actually advances: not in reset and not globally frozen.
    logic live;
    logic in_req;
    logic in_dispatch;

    assign live        = rdy_in && !rst_in;
    assign in_req      = !rst_in && (state_q == ST_REQ);
    assign in_dispatch = !rst_in && (state_q == ST_DISPATCH);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case statement can leave it unassigned and infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;

        if (_br_rob) begin
            // Redirect beats everything: the in-flight response and any pending
            // push are dropped, and fetch restarts at the ROB target.
            pc_d    = _dec_next_pc;
            state_d = ST_REQ;
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (_ic_resp_valid) begin
                        inst_d  = _ic_resp_data;
                        state_d = ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    if (!_iq_full) begin
                        pc_d    = _dec_next_pc;
                        state_d = _dec_stall ? ST_JSTALL : ST_REQ;
                    end
                end
                ST_JSTALL: begin
                    // Idle until a ROB redirect supplies the jalr target.
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers: synchronous reset wins over rdy_in; rdy_in low holds.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst_in) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Requests are always halfword aligned; bit 0 of the PC is never fetched.
    assign _ic_req   = in_req;
    assign _ic_addr  = {pc_q[XLEN-1:1], 1'b0};
    // Abort only matters when a request is actually outstanding.
    assign _ic_abort = live && _br_rob && in_req;

    assign _inst_ready_out = in_dispatch;
    assign _inst_out       = inst_q;
    assign _inst_addr_out  = pc_q;
    assign _clear          = _br_rob;

    // Push is combinational in the dispatch cycle; a coincident redirect drops it.
    assign _iq_push    = live && !_br_rob && in_dispatch && !_iq_full;
    assign _iq_inst    = in_dispatch ? _dec_inst    : '0;
    assign _iq_pc      = in_dispatch ? pc_q         : '0;
    assign _iq_pred_pc = in_dispatch ? _dec_next_pc : '0;
    assign _iq_rvc     = in_dispatch && _dec_rvc;

endmodule : inst_fetcher

// File: tb/tb_inst_fetcher.sv
// -----------------------------------------------------------------------------
// tb_inst_fetcher
//   Drives inst_fetcher with a behavioural icache and a small Decoder model.
//   Expected IQ pushes are queued when the icache response is driven and are
//   compared when the fetcher raises _iq_push.
// -----------------------------------------------------------------------------
module tb_inst_fetcher;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pred;
        logic [31:0] rvc;
    } push_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        br_rob;
    logic [31:0] rob_target;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_abort;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_data;
    logic [31:0] inst_out;
    logic        inst_ready;
    logic [31:0] inst_addr;
    logic        clear;
    logic        dec_stall;
    logic [31:0] dec_next_pc;
    logic [31:0] dec_inst;
    logic        dec_rvc;
    logic [31:0] dec_seq_pc;
    logic        iq_full;
    logic        iq_push;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic [31:0] iq_pred_pc;
    logic        iq_rvc;

    int    n_vec  = 0;
    int    n_miss = 0;
    int    n_push = 0;
    push_t sb[$];

    always #5 clk_in = ~clk_in;

    inst_fetcher #(.RESET_PC(32'h0000_0000)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        ._br_rob       (br_rob),
        ._ic_req       (ic_req),
        ._ic_addr      (ic_addr),
        ._ic_abort     (ic_abort),
        ._ic_resp_valid(ic_resp_valid),
        ._ic_resp_data (ic_resp_data),
        ._inst_out     (inst_out),
        ._inst_ready_out(inst_ready),
        ._inst_addr_out(inst_addr),
        ._clear        (clear),
        ._dec_stall    (dec_stall),
        ._dec_next_pc  (dec_next_pc),
        ._dec_inst     (dec_inst),
        ._dec_rvc      (dec_rvc),
        ._iq_full      (iq_full),
        ._iq_push      (iq_push),
        ._iq_inst      (iq_inst),
        ._iq_pc        (iq_pc),
        ._iq_pred_pc   (iq_pred_pc),
        ._iq_rvc       (iq_rvc)
    );

    // Decoder stand-in: expands c.li, flags jalr, predicts fall-through, and
    // forwards the ROB target while a redirect is active.
    always_comb begin
        dec_rvc    = (inst_out[1:0] != 2'b11);
        dec_stall  = 1'b0;
        dec_inst   = inst_out;
        dec_seq_pc = inst_addr + 32'd4;
        if (dec_rvc) begin
            dec_seq_pc = inst_addr + 32'd2;
            if (inst_out[15:13] == 3'b010 && inst_out[1:0] == 2'b01)
                dec_inst = {{6{inst_out[12]}}, inst_out[12], inst_out[6:2],
                            5'd0, 3'b000, inst_out[11:7], 7'b0010011};
            else
                dec_inst = {16'h0000, inst_out[15:0]};
        end else begin
            dec_stall = (inst_out[6:0] == 7'b1100111);
        end
        dec_next_pc = br_rob ? rob_target : dec_seq_pc;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Scoreboard consumer: each push must match the oldest expected entry.
    always @(negedge clk_in) begin
        if (iq_push === 1'b1) begin
            n_push++;
            if (sb.size() == 0) begin
                check("iq_push_unexpected", 32'(iq_push), 32'd0);
            end else begin
                push_t e;
                e = sb.pop_front();
                check("iq_pc",      iq_pc,           e.pc);
                check("iq_inst",    iq_inst,         e.inst);
                check("iq_pred_pc", iq_pred_pc,      e.pred);
                check("iq_rvc",     32'(iq_rvc),     e.rvc);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic expect_push(input logic [31:0] pc, input logic [31:0] inst,
                               input logic [31:0] pred, input logic [31:0] rvc);
        push_t e;
        e.pc = pc; e.inst = inst; e.pred = pred; e.rvc = rvc;
        sb.push_back(e);
    endtask

    // Bounded wait for an icache request, then check its address.
    task automatic wait_req(input logic [31:0] exp_addr);
        int n;
        n = 0;
        #1;
        while (ic_req !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (ic_req !== 1'b1) check("ic_req_wait", 32'(ic_req), 32'd1);
        check("ic_addr", ic_addr, exp_addr);
    endtask

    // Answer the pending request 'lat' cycles after it is seen.
    task automatic respond(input logic [31:0] exp_addr, input logic [31:0] data, input int lat);
        wait_req(exp_addr);
        repeat (lat) tick();
        ic_resp_valid = 1'b1;
        ic_resp_data  = data;
        tick();
        ic_resp_valid = 1'b0;
        ic_resp_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; br_rob = 1'b0; rob_target = '0;
        ic_resp_valid = 1'b0; ic_resp_data = '0; iq_full = 1'b0;
        tick(); tick();
        #1;
        check("rst_ic_req",     32'(ic_req),     32'd0);
        check("rst_ic_abort",   32'(ic_abort),   32'd0);
        check("rst_inst_ready", 32'(inst_ready), 32'd0);
        check("rst_inst_out",   inst_out,        32'd0);
        rst_in = 1'b0;
        tick();

        // 1: 32-bit addi at reset PC, response two cycles after request.
        expect_push(32'h0, 32'h0010_0093, 32'h4, 32'd0);
        respond(32'h0, 32'h0010_0093, 2);
        #1;
        check("t1_inst_ready", 32'(inst_ready), 32'd1);
        check("t1_inst_out",   inst_out,        32'h0010_0093);
        check("t1_inst_addr",  inst_addr,       32'h0);
        check("t1_ic_req",     32'(ic_req),     32'd0);
        tick();

        // 2: c.li a0,1 in the low half of the word at 4.
        expect_push(32'h4, 32'h0010_0513, 32'h6, 32'd1);
        respond(32'h4, 32'h0001_4505, 1);
        tick();

        // 3: compressed at 6 with the IQ full for three cycles.
        expect_push(32'h6, 32'h0010_0513, 32'h8, 32'd1);
        respond(32'h6, 32'h0000_4505, 1);
        iq_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_full_push",  32'(iq_push),    32'd0);
            check("t3_full_req",   32'(ic_req),     32'd0);
            check("t3_full_ready", 32'(inst_ready), 32'd1);
            tick();
        end
        iq_full = 1'b0;
        #1;
        check("t3_push_on_drop", 32'(iq_push), 32'd1);
        tick();
        #1;
        check("t3_single_push", 32'(iq_push), 32'd0);

        // 4: jalr at 8 enters JSTALL until the ROB supplies 0x100.
        expect_push(32'h8, 32'h0000_8067, 32'hC, 32'd0);
        respond(32'h8, 32'h0000_8067, 1);
        tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t4_jstall_req",   32'(ic_req),     32'd0);
            check("t4_jstall_ready", 32'(inst_ready), 32'd0);
            tick();
        end
        br_rob = 1'b1; rob_target = 32'h100;
        #1;
        check("t4_clear", 32'(clear),    32'd1);
        check("t4_abort", 32'(ic_abort), 32'd0);
        tick();
        br_rob = 1'b0;
        expect_push(32'h100, 32'h0000_0013, 32'h104, 32'd0);
        respond(32'h100, 32'h0000_0013, 1);
        tick();

        // 5: redirect in REQ to 0x20, then redirect colliding with a response.
        wait_req(32'h104);
        br_rob = 1'b1; rob_target = 32'h20;
        #1;
        check("t5_abort_a", 32'(ic_abort), 32'd1);
        tick();
        br_rob = 1'b0;
        wait_req(32'h20);
        tick();
        br_rob = 1'b1; rob_target = 32'h40;
        ic_resp_valid = 1'b1; ic_resp_data = 32'h0050_0293;
        #1;
        check("t5_abort_b", 32'(ic_abort), 32'd1);
        check("t5_no_push", 32'(iq_push),  32'd0);
        check("t5_clear",   32'(clear),    32'd1);
        tick();
        br_rob = 1'b0; ic_resp_valid = 1'b0; ic_resp_data = '0;
        #1;
        check("t5_discard_ready", 32'(inst_ready), 32'd0);
        check("t5_ic_req",        32'(ic_req),     32'd1);
        check("t5_ic_addr",       ic_addr,         32'h40);

        // 6: freeze in DISPATCH, then reset mid-stream (instruction never pushed).
        respond(32'h40, 32'h0030_0193, 1);
        rdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t6_frozen_push",  32'(iq_push),    32'd0);
            check("t6_frozen_ready", 32'(inst_ready), 32'd1);
            check("t6_frozen_addr",  inst_addr,       32'h40);
            tick();
        end
        rst_in = 1'b1;
        #1;
        check("t6_rst_req",   32'(ic_req),     32'd0);
        check("t6_rst_ready", 32'(inst_ready), 32'd0);
        check("t6_rst_push",  32'(iq_push),    32'd0);
        check("t6_rst_abort", 32'(ic_abort),   32'd0);
        tick();
        #1;
        check("t6_rst_ic_addr",  ic_addr,  32'h0);
        check("t6_rst_inst_out", inst_out, 32'h0);
        check("t6_rst_iq_pc",    iq_pc,    32'h0);
        rst_in = 1'b0; rdy_in = 1'b1;
        tick();
        #1;
        check("t6_post_req",  32'(ic_req), 32'd1);
        check("t6_post_addr", ic_addr,     32'h0);

        check("sb_drained",  32'(sb.size()), 32'd0);
        check("push_total",  32'(n_push),    32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_inst_fetcher

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end stage directly upstream of the Decoder; owns the architectural fetch PC.
- Requests halfword-aligned 32-bit words from the icache and presents each raw instruction plus its address to the Decoder.
- Uses the Decoder's `_next_pc`, `_stall`, `_formalized_inst` and `_rvc` to advance the PC and push decoded entries into the instruction queue.
- Handles ROB redirects, jalr stalls and queue back-pressure.

Parameters:
- RESET_PC, 32'h0000_0000: fetch address loaded on reset.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global ready; low freezes all state
- _br_rob  in  1  ROB redirect (mispredict or jalr resolve) this cycle
- _ic_req  out  1  icache request, level
- _ic_addr  out  32  request address, bit0 always 0
- _ic_abort  out  1  cancel outstanding icache request
- _ic_resp_valid  in  1  icache data valid, one cycle
- _ic_resp_data  in  32  32 bits starting at _ic_addr
- _inst_out  out  32  raw instruction to Decoder
- _inst_ready_out  out  1  _inst_out valid
- _inst_addr_out  out  32  PC of _inst_out
- _clear  out  1  flush to Decoder, equals _br_rob
- _dec_stall  in  1  Decoder: jalr seen, wait for ROB
- _dec_next_pc  in  32  Decoder: predicted next PC, or ROB target when _br_rob=1
- _dec_inst  in  32  Decoder: formalized 32-bit instruction
- _dec_rvc  in  1  Decoder: source was compressed
- _iq_full  in  1  instruction queue cannot accept
- _iq_push  out  1  push strobe
- _iq_inst  out  32  formalized instruction
- _iq_pc  out  32  instruction PC
- _iq_pred_pc  out  32  predicted successor PC
- _iq_rvc  out  1  compressed flag

Behaviour:
- Reset (rst_in=1, overrides everything incl. rdy_in):
  - pc=RESET_PC; state=REQ; inst_reg=0.
  - All strobes (_ic_req, _ic_abort, _inst_ready_out, _iq_push) deasserted.
  - Data outputs reset to 0.
- rdy_in=0: no register updates, no push, no abort; outputs hold their previous values.
- States:
  - REQ: _ic_req=1, _ic_addr={pc[31:1],1'b0}.
    - On _ic_resp_valid: inst_reg<=_ic_resp_data → DISPATCH.
    - Response latency ≥1 cycle after _ic_req first rises.
  - DISPATCH: _inst_ready_out=1, _inst_out=inst_reg, _inst_addr_out=pc.
    - If !_iq_full: _iq_push=1 (combinational, same cycle) with _iq_inst=_dec_inst, _iq_pc=pc, _iq_pred_pc=_dec_next_pc, _iq_rvc=_dec_rvc. Then pc<=_dec_next_pc; next state JSTALL if _dec_stall, else REQ.
    - If _iq_full: hold, no push, no PC change.
  - JSTALL: _inst_ready_out=0, _ic_req=0. Waits for _br_rob.
- Redirect (_br_rob=1, any state):
  - pc<=_dec_next_pc; state<=REQ.
  - _iq_push forced 0; _ic_resp_valid ignored this cycle.
  - _ic_abort=1 if the state was REQ.
  - _clear=_br_rob.
  - If redirect and push coincide in DISPATCH, redirect wins and the instruction is dropped.
- Exactly one push per fetched instruction. No fetch while in DISPATCH or JSTALL (single in-flight).
- PC arithmetic is entirely in the Decoder. The fetcher only latches _dec_next_pc; wrap modulo 2^32.

Decomposition:
- fetch_pkg: state enum (REQ, DISPATCH, JSTALL), RESET_PC default, XLEN=32.
- No sub-module. Decoder is instantiated beside this block in the front-end top, not inside it.

Test Plan:
1. Reset with RESET_PC=0, resp 0x00100093 two cycles after req → _ic_addr=0; push _iq_pc=0, _iq_inst=0x00100093, _iq_pred_pc=4, _iq_rvc=0; next _ic_addr=4.
2. pc=4, resp low half 0x4505 (c.li a0,1) → push _iq_inst=0x00100513, _iq_rvc=1, _iq_pred_pc=6; next _ic_addr=6.
3. DISPATCH with _iq_full=1 for 3 cycles → no push and _ic_req=0 during those cycles; exactly one push on the cycle full drops.
4. pc=8, inst 0x00008067 (jalr) → pushed, enters JSTALL, _ic_req=0 for 10 idle cycles. Then _br_rob with Decoder target 0x100 → next _ic_addr=0x100.
5. REQ at 0x20, _br_rob=1 and _ic_resp_valid=1 in the same cycle, target 0x40 → response discarded, _ic_abort=1, no push; next _ic_addr=0x40.
6. DISPATCH with rdy_in=0 for 2 cycles, then rst_in=1 mid-stream → no push while frozen; after reset _ic_addr=RESET_PC and all strobes are 0.
